// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide, 1-cycle synchronous-read data memory for
// byte/halfword/word accesses, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t            state, state_next;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  logic              req_word, req_half, misaligned;
  logic [ADDR_W-1:0] eff_addr;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_data, merged;

  // Size code 3 shares the word path because only size[1] selects word access.
  always_comb begin
    req_word   = req_size[1];
    req_half   = (req_size == 2'd1);
    misaligned = CHECK_ALIGN && ((req_half && req_addr[0]) ||
                                 (req_word && (req_addr[1:0] != 2'b00)));
    eff_addr   = req_addr;
    if (!CHECK_ALIGN) begin
      if (req_word)      eff_addr[1:0] = 2'b00;
      else if (req_half) eff_addr[0]   = 1'b0;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    if (size_q[1])
      load_data = mem_rdata;
    else if (size_q == 2'd1)
      load_data = {{16{signed_q & lane_half[15]}}, lane_half};
    else
      load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};

    merged = mem_rdata;
    if (size_q == 2'd1) begin
      if (addr_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)                  state_next = ERR;
          else if (!req_write || !req_word) state_next = READ;
          else                             state_next = WRITE;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = write_q ? WRITE : IDLE;
      WRITE:   state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Responses are registered on the edge leaving WAIT/WRITE/ERR, so resp_valid
  // coincides with the first IDLE cycle and busy is already low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= eff_addr;
            wdata_q  <= req_wdata[15:0];
            if (req_write && req_word && !misaligned) mem_wdata <= req_wdata;
          end
        end
        WAIT: begin
          if (write_q) begin
            mem_wdata <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WRITE: resp_valid <= 1'b1;
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    mem_re   = (state == READ);
    mem_we   = (state == WRITE);
    mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected memory
// events and responses; negedge monitors pop and compare them with cycle stamps.
module tb_load_store_unit;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        na_req_valid, na_req_write, na_req_signed;
  logic [1:0]  na_req_size;
  logic [31:0] na_req_addr, na_req_wdata;
  logic        na_busy, na_resp_valid, na_resp_err, na_mem_we, na_mem_re;
  logic [31:0] na_resp_rdata, na_mem_addr, na_mem_wdata, na_mem_rdata;

  logic [31:0] mem [0:63];
  ev_t resp_q[$], re_q[$], we_q[$], na_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(na_req_valid), .req_write(na_req_write),
    .req_size(na_req_size), .req_signed(na_req_signed), .req_addr(na_req_addr),
    .req_wdata(na_req_wdata), .busy(na_busy), .resp_valid(na_resp_valid),
    .resp_err(na_resp_err), .resp_rdata(na_resp_rdata), .mem_addr(na_mem_addr),
    .mem_wdata(na_mem_wdata), .mem_we(na_mem_we), .mem_re(na_mem_re),
    .mem_rdata(na_mem_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8]  <= 32'h80FF7F01;
      mem[12] <= 32'h11223344;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(posedge clk)
    if (na_mem_re) na_mem_rdata <= 32'hC0DE0000 | na_mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : mon
    ev_t ev;
    if (mem_re && mem_we) fail("mem_re_we_overlap");
    if (mem_re) begin
      if (re_q.size() == 0) fail("unexpected_mem_re");
      else begin
        ev = re_q.pop_front();
        check("mem_re_cycle", cyc, ev.cyc);
        check("mem_re_addr", mem_addr, ev.addr);
      end
    end
    if (mem_we) begin
      if (we_q.size() == 0) fail("unexpected_mem_we");
      else begin
        ev = we_q.pop_front();
        check("mem_we_cycle", cyc, ev.cyc);
        check("mem_we_addr", mem_addr, ev.addr);
        check("mem_wdata", mem_wdata, ev.data);
      end
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) fail("unexpected_resp");
      else begin
        ev = resp_q.pop_front();
        check("resp_cycle", cyc, ev.cyc);
        check("resp_err", 32'(resp_err), 32'(ev.err));
        check("resp_rdata", resp_rdata, ev.data);
        check("resp_busy", 32'(busy), 32'h0);
      end
    end
  end

  always @(negedge clk) begin : mon_na
    ev_t ev;
    if (na_mem_we) fail("na_unexpected_mem_we");
    if (na_mem_re && na_q.size() != 0) check("na_mem_addr", na_mem_addr, na_q[0].addr);
    if (na_resp_valid) begin
      if (na_q.size() == 0) fail("na_unexpected_resp");
      else begin
        ev = na_q.pop_front();
        check("na_resp_cycle", cyc, ev.cyc);
        check("na_resp_err", 32'(na_resp_err), 32'(ev.err));
        check("na_resp_rdata", na_resp_rdata, ev.data);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("busy_timeout");
  endtask

  task automatic expect_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic err, input logic [31:0] exp_rd,
                           input logic [31:0] exp_word, input int unsigned e);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (err) begin
      resp_q.push_back('{e + 2, 1'b1, 32'h0, 32'h0});
    end else if (!wr) begin
      re_q.push_back('{e + 1, 1'b0, wa, 32'h0});
      resp_q.push_back('{e + 3, 1'b0, 32'h0, exp_rd});
    end else if (sz[1]) begin
      we_q.push_back('{e + 1, 1'b0, wa, exp_word});
      resp_q.push_back('{e + 2, 1'b0, 32'h0, 32'h0});
    end else begin
      re_q.push_back('{e + 1, 1'b0, wa, 32'h0});
      we_q.push_back('{e + 3, 1'b0, wa, exp_word});
      resp_q.push_back('{e + 4, 1'b0, 32'h0, 32'h0});
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic err,
                       input logic [31:0] exp_rd, input logic [31:0] exp_word);
    wait_idle();
    drive(wr, sz, sg, a, wd);
    expect_op(wr, sz, a, err, exp_rd, exp_word, cyc);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic na_issue(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] exp_addr, input logic [31:0] exp_rd);
    int unsigned n = 0;
    @(negedge clk);
    while (na_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (na_busy) fail("na_busy_timeout");
    na_req_valid  = 1'b1;
    na_req_write  = 1'b0;
    na_req_size   = sz;
    na_req_signed = sg;
    na_req_addr   = a;
    na_q.push_back('{cyc + 3, 1'b0, exp_addr, exp_rd});
    @(posedge clk);
    #1 na_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    na_req_valid = 1'b0; na_req_write = 1'b0; na_req_size = 2'd0; na_req_signed = 1'b0;
    na_req_addr = 32'h0; na_req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0; preload = 1'b0;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h00000001, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b0, 32'h0000007F, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b0, 32'h00000080, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00007F01, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h31, 32'hFFFFFFAA, 1'b0, 32'h0, 32'h1122AA44);
    issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 1'b0, 32'h0, 32'hBEEFAA44);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 32'hBEEFAA44, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1'b1, 32'h0, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h33, 32'h1234, 1'b1, 32'h0, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 1'b0, 32'hBEEFAA44, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h32, 32'h5555, 1'b1, 32'h0, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0);

    // Back-to-back: second request held during busy, taken in the response cycle.
    wait_idle();
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    e = cyc;
    expect_op(1'b0, 2'd2, 32'h10, 1'b0, 32'hDEADBEEF, 32'h0, e);
    @(posedge clk);
    #1 drive(1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
    expect_op(1'b0, 2'd0, 32'h22, 1'b0, 32'hFFFFFFFF, 32'h0, e + 3);
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;

    // Reset asserted in the WAIT cycle of a byte store.
    wait_idle();
    drive(1'b1, 2'd0, 1'b0, 32'h10, 32'h55);
    e = cyc;
    re_q.push_back('{e + 1, 1'b0, 32'h10, 32'h0});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);

    na_issue(2'd2, 1'b0, 32'h41, 32'h40, 32'hC0DE0040);
    na_issue(2'd1, 1'b1, 32'h43, 32'h40, 32'hFFFFC0DE);
    na_issue(2'd0, 1'b0, 32'h43, 32'h40, 32'h000000C0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("resp_q_left", 32'(resp_q.size()), 32'h0);
    check("re_q_left", 32'(re_q.size()), 32'h0);
    check("we_q_left", 32'(we_q.size()), 32'h0);
    check("na_q_left", 32'(na_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts load/store requests from the EX/MEM pipeline register and drives the word-wide, 1-cycle synchronous-read data memory.
- Supports byte, halfword and word access. Loads are sign- or zero-extended. Sub-word stores use read-modify-write.
- Returns a registered response to the MEM/WB stage and raises busy so the hazard logic stalls the pipeline.

Parameters:
- ADDR_W, 32, byte-address width.
- CHECK_ALIGN, 1, 1 = misaligned halfword/word requests are rejected with resp_err; 0 = address low bits are ignored (forced aligned).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe; sampled only when busy=0.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- req_signed  in  1  load sign-extension enable (ignored for stores).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- busy  out  1  high while a request is in flight (state != IDLE).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = misaligned, no memory access made.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  write word.
- mem_we  out  1  write enable.
- mem_re  out  1  read enable.
- mem_rdata  in  32  read word; valid the cycle after mem_re is sampled.

Behaviour:
- Reset values: state=IDLE, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, all latched request fields 0. rst overrides all activity, including mid-operation: any in-flight request is dropped with no response and no mem_we.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]. Halfword lane = addr[1].
- Alignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is misaligned (when CHECK_ALIGN=1).
- FSM states: IDLE, READ, WAIT, WRITE, ERR.
- IDLE: on req_valid, latch all req_* fields.
  - Misaligned -> ERR.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
  - Without req_valid, stay in IDLE.
- READ: mem_re=1, mem_addr set. Next state WAIT.
- WAIT: mem_rdata is valid.
  - Load: select the lane, extend per req_signed, register into resp_rdata; pulse resp_valid; -> IDLE.
  - Sub-word store: merge store bytes into mem_rdata, register into mem_wdata; -> WRITE.
- WRITE: mem_we=1. mem_wdata = merged word, or req_wdata for a word store. Pulse resp_valid (resp_rdata=0) on the exiting edge; -> IDLE.
- ERR: resp_valid=1 and resp_err=1 on the exiting edge; -> IDLE. mem_we and mem_re stay 0.
- mem_we and mem_re are never asserted in the same cycle.
- Latency from the accepting edge E:
  - Load: mem_re high in cycle E+1; resp_valid in cycle E+3.
  - Word store: mem_we high in cycle E+1; resp_valid in cycle E+2.
  - Sub-word store: mem_re E+1, mem_we E+3, resp_valid E+4.
  - Error: resp_valid in cycle E+2.
- The request accepted in cycle E is the one sampled on the rising edge that ends cycle E.
- busy goes high the cycle after acceptance and stays high until the cycle resp_valid is asserted (busy=0 in that cycle). A new request may be accepted in that same cycle: back-to-back operation.
- req_valid while busy=1 is ignored (not queued). Requesters must hold the request until busy has fallen.
- Size code 3 behaves exactly as a word access.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> mem_we once at E+1, mem_wdata 0xDEADBEEF; load 0x10 -> resp_rdata 0xDEADBEEF at E+3, resp_err=0.
- Signed/unsigned byte load: memory word 0x80FF7F01 at 0x20; byte loads at 0x20..0x23 signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned addr 0x23 -> 0x00000080.
- Sub-word store RMW: memory 0x11223344 at 0x30; byte store 0xAA to 0x31 -> mem_re E+1, mem_we E+3, word becomes 0x1122AA44; halfword store 0xBEEF to 0x32 -> 0xBEEFAA44.
- Misalignment: word load at 0x41 -> resp_valid and resp_err at E+2, resp_rdata 0, no mem_re or mem_we; with CHECK_ALIGN=0 -> reads word 0x40.
- Busy/back-to-back: req_valid held high through a load; a second request presented during busy is ignored until busy falls, then accepted in the resp_valid cycle; exactly two responses.
- Reset mid-RMW: assert rst in the WAIT cycle of a byte store -> no mem_we, no resp_valid, busy=0 and all outputs 0 on the next cycle, memory unchanged.
